rs_wakeup_array: RTL and testbench

Reservation-station storage and wakeup stage for the out-of-order core. It sits between rename/dispatch and the select arbiter. It accepts dispatched micro-ops and tracks source-operand readiness from result-tag broadcasts. Each cycle it drives a per-entry request vector to select, then retires the granted entry into a registered issue slot for register read.

---
 rtl/rs_wakeup_array_if.sv | 46 ++++
 rtl/rs_wakeup_array.sv | 160 ++++++++++++++++
 tb/tb_rs_wakeup_array.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rs_wakeup_array_if.sv
// Dispatch / wakeup / select / issue bundle for the reservation-station wakeup array.
// The master side (dispatch, broadcast and select logic) drives requests; the slave is the RS.
interface rs_wakeup_array_if #(
  parameter int RS_ENTRIES = 8,
  parameter int PREG_W     = 6,
  parameter int PAYLOAD_W  = 32,
  parameter int NUM_WAKEUP = 2
) ();
  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  logic                         flush;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [PREG_W-1:0]            disp_src1_tag;
  logic                         disp_src1_rdy;
  logic [PREG_W-1:0]            disp_src2_tag;
  logic                         disp_src2_rdy;
  logic [PREG_W-1:0]            disp_dst_tag;
  logic [PAYLOAD_W-1:0]         disp_payload;
  logic [NUM_WAKEUP-1:0]        wk_valid;
  logic [NUM_WAKEUP*PREG_W-1:0] wk_tag;
  logic [RS_ENTRIES-1:0]        request_vector;
  logic [IDX_W-1:0]             grant_index;
  logic                         grant_en;
  logic                         iss_valid;
  logic [PREG_W-1:0]            iss_src1_tag;
  logic [PREG_W-1:0]            iss_src2_tag;
  logic [PREG_W-1:0]            iss_dst_tag;
  logic [PAYLOAD_W-1:0]         iss_payload;
  logic [CNT_W-1:0]             rs_count;

  modport master (
    output flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag, disp_src2_rdy,
           disp_dst_tag, disp_payload, wk_valid, wk_tag, grant_index, grant_en,
    input  disp_ready, request_vector, iss_valid, iss_src1_tag, iss_src2_tag, iss_dst_tag,
           iss_payload, rs_count
  );

  modport slave (
    input  flush, disp_valid, disp_src1_tag, disp_src1_rdy, disp_src2_tag, disp_src2_rdy,
           disp_dst_tag, disp_payload, wk_valid, wk_tag, grant_index, grant_en,
    output disp_ready, request_vector, iss_valid, iss_src1_tag, iss_src2_tag, iss_dst_tag,
           iss_payload, rs_count
  );
endinterface

// File: rtl/rs_wakeup_array.sv
// Reservation-station storage: allocates dispatched micro-ops, wakes sources on tag
// broadcasts, raises per-entry requests and moves the granted entry into an issue register.
module rs_wakeup_array #(
  parameter int RS_ENTRIES = 8,
  parameter int PREG_W     = 6,
  parameter int PAYLOAD_W  = 32,
  parameter int NUM_WAKEUP = 2
) (
  input  logic              clk,
  input  logic              rst,
  rs_wakeup_array_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [RS_ENTRIES-1:0]                r_valid;
  logic [RS_ENTRIES-1:0]                r_src1_rdy;
  logic [RS_ENTRIES-1:0]                r_src2_rdy;
  logic [RS_ENTRIES-1:0][PREG_W-1:0]    r_src1_tag;
  logic [RS_ENTRIES-1:0][PREG_W-1:0]    r_src2_tag;
  logic [RS_ENTRIES-1:0][PREG_W-1:0]    r_dst_tag;
  logic [RS_ENTRIES-1:0][PAYLOAD_W-1:0] r_payload;

  logic                 r_iss_valid;
  logic [PREG_W-1:0]    r_iss_src1_tag;
  logic [PREG_W-1:0]    r_iss_src2_tag;
  logic [PREG_W-1:0]    r_iss_dst_tag;
  logic [PAYLOAD_W-1:0] r_iss_payload;
  logic [CNT_W-1:0]     r_count;

  logic                  w_free_any;
  logic                  w_alloc;
  logic                  w_grant;
  logic [IDX_W-1:0]      w_alloc_idx;
  logic                  w_disp_s1_hit;
  logic                  w_disp_s2_hit;
  logic [RS_ENTRIES-1:0] w_s1_hit;
  logic [RS_ENTRIES-1:0] w_s2_hit;
  logic [RS_ENTRIES-1:0] w_request;

  function automatic logic tag_hit(
    input logic [PREG_W-1:0]            tag,
    input logic [NUM_WAKEUP-1:0]        vld,
    input logic [NUM_WAKEUP*PREG_W-1:0] tags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WAKEUP; k++) begin
      hit = hit | (vld[k] & (tags[k*PREG_W +: PREG_W] == tag));
    end
    return hit;
  endfunction

  // Lowest-index free entry: scan downwards so the smallest index wins.
  always_comb begin
    w_alloc_idx = {IDX_W{1'b0}};
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_idx = IDX_W'(i);
      end else begin
        w_alloc_idx = w_alloc_idx;
      end
    end
  end

  // Broadcast tag matches for stored entries and for the micro-op being dispatched.
  always_comb begin
    w_s1_hit = {RS_ENTRIES{1'b0}};
    w_s2_hit = {RS_ENTRIES{1'b0}};
    for (int i = 0; i < RS_ENTRIES; i++) begin
      w_s1_hit[i] = tag_hit(r_src1_tag[i], bus.wk_valid, bus.wk_tag);
      w_s2_hit[i] = tag_hit(r_src2_tag[i], bus.wk_valid, bus.wk_tag);
    end
    w_disp_s1_hit = tag_hit(bus.disp_src1_tag, bus.wk_valid, bus.wk_tag);
    w_disp_s2_hit = tag_hit(bus.disp_src2_tag, bus.wk_valid, bus.wk_tag);
  end

  assign w_free_any = ~&r_valid;
  assign w_request  = r_valid & r_src1_rdy & r_src2_rdy;
  assign w_alloc    = bus.disp_valid & bus.disp_ready;
  assign w_grant    = ~bus.flush & bus.grant_en & w_request[bus.grant_index];

  assign bus.disp_ready     = ~rst & ~bus.flush & w_free_any;
  assign bus.request_vector = w_request;
  assign bus.iss_valid      = r_iss_valid;
  assign bus.iss_src1_tag   = r_iss_src1_tag;
  assign bus.iss_src2_tag   = r_iss_src2_tag;
  assign bus.iss_dst_tag    = r_iss_dst_tag;
  assign bus.iss_payload    = r_iss_payload;
  assign bus.rs_count       = r_count;

  // Entry storage: allocation, wakeup and release on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= {RS_ENTRIES{1'b0}};
      r_src1_rdy <= {RS_ENTRIES{1'b0}};
      r_src2_rdy <= {RS_ENTRIES{1'b0}};
      r_src1_tag <= '0;
      r_src2_tag <= '0;
      r_dst_tag  <= '0;
      r_payload  <= '0;
    end else if (bus.flush) begin
      r_valid <= {RS_ENTRIES{1'b0}};
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (w_alloc && (w_alloc_idx == IDX_W'(i))) begin
          // Same-cycle broadcast bypass so a wakeup racing dispatch is not lost.
          r_valid[i]    <= 1'b1;
          r_src1_tag[i] <= bus.disp_src1_tag;
          r_src2_tag[i] <= bus.disp_src2_tag;
          r_dst_tag[i]  <= bus.disp_dst_tag;
          r_payload[i]  <= bus.disp_payload;
          r_src1_rdy[i] <= bus.disp_src1_rdy | w_disp_s1_hit;
          r_src2_rdy[i] <= bus.disp_src2_rdy | w_disp_s2_hit;
        end else begin
          r_src1_rdy[i] <= r_src1_rdy[i] | (r_valid[i] & w_s1_hit[i]);
          r_src2_rdy[i] <= r_src2_rdy[i] | (r_valid[i] & w_s2_hit[i]);
          if (w_grant && (bus.grant_index == IDX_W'(i))) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Issue slot: one-cycle pulse carrying the granted entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_valid    <= 1'b0;
      r_iss_src1_tag <= {PREG_W{1'b0}};
      r_iss_src2_tag <= {PREG_W{1'b0}};
      r_iss_dst_tag  <= {PREG_W{1'b0}};
      r_iss_payload  <= {PAYLOAD_W{1'b0}};
    end else begin
      r_iss_valid <= w_grant;
      if (w_grant) begin
        r_iss_src1_tag <= r_src1_tag[bus.grant_index];
        r_iss_src2_tag <= r_src2_tag[bus.grant_index];
        r_iss_dst_tag  <= r_dst_tag[bus.grant_index];
        r_iss_payload  <= r_payload[bus.grant_index];
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (bus.flush) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_alloc && !w_grant) begin
      r_count <= r_count + CNT_ONE;
    end else if (!w_alloc && w_grant) begin
      r_count <= r_count - CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end
endmodule

// File: tb/tb_rs_wakeup_array.sv
// Directed bench for rs_wakeup_array: a vector table for single-cycle behaviour plus
// hand sequences for full occupancy, flush and asynchronous reset.
module tb_rs_wakeup_array;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rs_wakeup_array_if #(.RS_ENTRIES(8), .PREG_W(6), .PAYLOAD_W(32), .NUM_WAKEUP(2)) ifc ();

  rs_wakeup_array #(.RS_ENTRIES(8), .PREG_W(6), .PAYLOAD_W(32), .NUM_WAKEUP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [5:0]  s1;
    logic        s1r;
    logic [5:0]  s2;
    logic        s2r;
    logic [5:0]  dst;
    logic [31:0] pl;
    logic [1:0]  wkv;
    logic [11:0] wkt;
    logic        ge;
    logic [2:0]  gi;
    logic [7:0]  e_rv;
    logic [3:0]  e_cnt;
    logic        e_iv;
    logic [5:0]  e_dst;
    logic [31:0] e_pl;
    logic        e_dr;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    ifc.flush         = 1'b0;
    ifc.disp_valid    = 1'b0;
    ifc.disp_src1_tag = 6'd0;
    ifc.disp_src1_rdy = 1'b0;
    ifc.disp_src2_tag = 6'd0;
    ifc.disp_src2_rdy = 1'b0;
    ifc.disp_dst_tag  = 6'd0;
    ifc.disp_payload  = 32'd0;
    ifc.wk_valid      = 2'b00;
    ifc.wk_tag        = 12'd0;
    ifc.grant_en      = 1'b0;
    ifc.grant_index   = 3'd0;
  endtask

  task automatic dispatch(input logic [5:0] s1, input logic s1r, input logic [5:0] s2,
                          input logic s2r, input logic [5:0] dst, input logic [31:0] pl);
    ifc.disp_valid    = 1'b1;
    ifc.disp_src1_tag = s1;
    ifc.disp_src1_rdy = s1r;
    ifc.disp_src2_tag = s2;
    ifc.disp_src2_rdy = s2r;
    ifc.disp_dst_tag  = dst;
    ifc.disp_payload  = pl;
  endtask

  task automatic grant(input logic [2:0] idx);
    ifc.grant_en    = 1'b1;
    ifc.grant_index = idx;
  endtask

  // One clock: inputs held across the edge, then returned to idle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  // Every grant the bench drives must target a requesting entry.
  always @(negedge clk) begin
    if (!rst && !ifc.flush && ifc.grant_en) begin
      n_checks++;
      if (!ifc.request_vector[ifc.grant_index]) begin
        n_fail++;
        $display("FAIL grant_target: entry %0d not requesting, rv=0x%0h", ifc.grant_index,
                 ifc.request_vector);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;

    //              dv s1    s1r s2   s2r dst    pl            wkv    wkt                ge gi    rv     cnt  iv dst    pl            dr
    vecs[0]  = '{1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'hAAAA0001, 2'b00, 12'd0, 1'b0, 3'd0, 8'h01, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[1]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b00, 12'd0, 1'b1, 3'd0, 8'h00, 4'd0, 1'b1, 6'd5, 32'hAAAA0001, 1'b1};
    vecs[2]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b00, 12'd0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[3]  = '{1'b1, 6'd12, 1'b0, 6'd3, 1'b1, 6'd9, 32'hAAAA0002, 2'b00, 12'd0, 1'b0, 3'd0, 8'h00, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[4]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b10, {6'd12, 6'd0}, 1'b0, 3'd0, 8'h01, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[5]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b00, 12'd0, 1'b1, 3'd0, 8'h00, 4'd0, 1'b1, 6'd9, 32'hAAAA0002, 1'b1};
    vecs[6]  = '{1'b1, 6'd4, 1'b1, 6'd7, 1'b0, 6'd11, 32'hAAAA0003, 2'b01, {6'd0, 6'd7}, 1'b0, 3'd0, 8'h01, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[7]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b00, 12'd0, 1'b1, 3'd0, 8'h00, 4'd0, 1'b1, 6'd11, 32'hAAAA0003, 1'b1};
    vecs[8]  = '{1'b1, 6'd20, 1'b0, 6'd1, 1'b1, 6'd21, 32'hAAAA0004, 2'b01, {6'd0, 6'd19}, 1'b0, 3'd0, 8'h00, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[9]  = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b11, {6'd20, 6'd19}, 1'b0, 3'd0, 8'h01, 4'd1, 1'b0, 6'd0, 32'd0, 1'b1};
    vecs[10] = '{1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 6'd22, 32'hAAAA0005, 2'b00, 12'd0, 1'b1, 3'd0, 8'h02, 4'd1, 1'b1, 6'd21, 32'hAAAA0004, 1'b1};
    vecs[11] = '{1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 2'b00, 12'd0, 1'b1, 3'd1, 8'h00, 4'd0, 1'b1, 6'd22, 32'hAAAA0005, 1'b1};

    repeat (2) @(posedge clk);
    #2;
    check("rst_rv", 32'(ifc.request_vector), 32'h0);
    check("rst_dr", 32'(ifc.disp_ready), 32'h0);
    check("rst_iv", 32'(ifc.iss_valid), 32'h0);
    check("rst_cnt", 32'(ifc.rs_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_dr", 32'(ifc.disp_ready), 32'h1);

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].dv) dispatch(vecs[v].s1, vecs[v].s1r, vecs[v].s2, vecs[v].s2r,
                               vecs[v].dst, vecs[v].pl);
      ifc.wk_valid = vecs[v].wkv;
      ifc.wk_tag   = vecs[v].wkt;
      if (vecs[v].ge) grant(vecs[v].gi);
      step();
      check($sformatf("v%0d_rv", v), 32'(ifc.request_vector), 32'(vecs[v].e_rv));
      check($sformatf("v%0d_cnt", v), 32'(ifc.rs_count), 32'(vecs[v].e_cnt));
      check($sformatf("v%0d_iv", v), 32'(ifc.iss_valid), 32'(vecs[v].e_iv));
      check($sformatf("v%0d_dr", v), 32'(ifc.disp_ready), 32'(vecs[v].e_dr));
      if (vecs[v].e_iv) begin
        check($sformatf("v%0d_idst", v), 32'(ifc.iss_dst_tag), 32'(vecs[v].e_dst));
        check($sformatf("v%0d_ipl", v), ifc.iss_payload, vecs[v].e_pl);
      end
    end

    // Fill all entries, then grant entry 3 while dispatch is offered.
    for (int i = 0; i < 8; i++) begin
      dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'(30 + i), 32'(i));
      step();
    end
    check("full_cnt", 32'(ifc.rs_count), 32'd8);
    check("full_dr", 32'(ifc.disp_ready), 32'd0);
    check("full_rv", 32'(ifc.request_vector), 32'hFF);
    dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 32'h50);
    grant(3'd3);
    #1;
    check("full_grant_dr", 32'(ifc.disp_ready), 32'd0);
    step();
    check("full_g3_iv", 32'(ifc.iss_valid), 32'd1);
    check("full_g3_dst", 32'(ifc.iss_dst_tag), 32'd33);
    check("full_g3_cnt", 32'(ifc.rs_count), 32'd7);
    check("full_g3_rv", 32'(ifc.request_vector), 32'hF7);
    check("full_g3_dr", 32'(ifc.disp_ready), 32'd1);
    dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd50, 32'h50);
    step();
    check("refill_rv", 32'(ifc.request_vector), 32'hFF);
    check("refill_cnt", 32'(ifc.rs_count), 32'd8);
    grant(3'd3);
    step();
    check("refill_dst", 32'(ifc.iss_dst_tag), 32'd50);
    check("refill_pl", ifc.iss_payload, 32'h50);

    // Drain to four entries, then flush with a dispatch and grant in the same cycle.
    for (int i = 0; i < 3; i++) begin
      grant(3'(i));
      step();
    end
    check("pre_flush_cnt", 32'(ifc.rs_count), 32'd4);
    ifc.flush = 1'b1;
    dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'd60, 32'h60);
    grant(3'd4);
    step();
    check("flush_cnt", 32'(ifc.rs_count), 32'd0);
    check("flush_rv", 32'(ifc.request_vector), 32'h0);
    check("flush_iv", 32'(ifc.iss_valid), 32'd0);
    check("flush_dr", 32'(ifc.disp_ready), 32'd1);

    // Asynchronous reset with three entries held and an issue pending.
    for (int i = 0; i < 4; i++) begin
      dispatch(6'd1, 1'b1, 6'd2, 1'b1, 6'(40 + i), 32'(i));
      step();
    end
    grant(3'd0);
    step();
    check("pre_rst_cnt", 32'(ifc.rs_count), 32'd3);
    check("pre_rst_iv", 32'(ifc.iss_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_rv", 32'(ifc.request_vector), 32'h0);
    check("arst_iv", 32'(ifc.iss_valid), 32'd0);
    check("arst_cnt", 32'(ifc.rs_count), 32'd0);
    check("arst_dr", 32'(ifc.disp_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("after_arst_rv", 32'(ifc.request_vector), 32'h0);
    check("after_arst_cnt", 32'(ifc.rs_count), 32'd0);
    check("after_arst_dr", 32'(ifc.disp_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
